// File: rtl/argmax_sequencer_if.sv
// argmax_sequencer_if: score input stream and result output handshake bundle.
//   score_valid/score_data/score_last/score_ready : frame of signed class scores
//   result_valid/result_ready/result_class/result_score : winning class per frame
//   slave modport is the sequencer side, master modport is the driver/consumer side.
interface argmax_sequencer_if #(
    parameter int DATA_W = 16
);
    logic                     score_valid;
    logic signed [DATA_W-1:0] score_data;
    logic                     score_last;
    logic                     score_ready;
    logic                     result_valid;
    logic                     result_ready;
    logic [31:0]              result_class;
    logic signed [DATA_W-1:0] result_score;

    modport master (
        output score_valid, score_data, score_last, result_ready,
        input  score_ready, result_valid, result_class, result_score
    );

    modport slave (
        input  score_valid, score_data, score_last, result_ready,
        output score_ready, result_valid, result_class, result_score
    );
endinterface

// File: rtl/argmax_sequencer.sv
// argmax_sequencer: collects one frame of NUM_CLASS signed scores and reports the argmax.
//   clk       : rising-edge clock
//   rst       : asynchronous active-low reset
//   bus       : argmax_sequencer_if.slave (score stream in, result handshake out)
//   busy      : high whenever the FSM is not IDLE
//   err_len   : sticky frame-length violation, cleared by the next frame's first accept
//   frame_cnt : completed result handshakes, only when ARGMAX_FRAME_COUNT_EN is defined
module argmax_sequencer #(
    parameter int DATA_W    = 16,
    parameter int NUM_CLASS = 10
) (
    input  logic clk,
    input  logic rst,
    argmax_sequencer_if.slave bus,
    output logic busy,
    output logic err_len
`ifdef ARGMAX_FRAME_COUNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);
    localparam int CNT_W = $clog2(NUM_CLASS + 1);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] DECIDE  = 2'd2;
    localparam logic [1:0] OUTPUT  = 2'd3;

    logic [1:0]               state;
    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         next_cnt;
    logic signed [DATA_W-1:0] slot [NUM_CLASS];
    logic                     accept;
    logic                     full;
    logic signed [DATA_W-1:0] best_score;
    logic [31:0]              best_class;

    assign bus.score_ready  = (state == IDLE) || (state == COLLECT);
    assign bus.result_valid = state == OUTPUT;
    assign busy             = state != IDLE;
    assign accept           = bus.score_valid && bus.score_ready;
    // A new frame restarts the slot count from zero.
    assign next_cnt         = (state == IDLE ? '0 : cnt) + CNT_W'(1);
    assign full             = next_cnt == CNT_W'(NUM_CLASS);

    // Ascending scan with >= lets the highest tied index win; only slots 1..cnt are candidates.
    always_comb begin
        best_score = slot[0];
        best_class = 32'd1;
        for (int i = 1; i < NUM_CLASS; i++)
            if (CNT_W'(i) < cnt && slot[i] >= best_score) begin
                best_score = slot[i];
                best_class = 32'(i + 1);
            end
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst)
            for (int i = 0; i < NUM_CLASS; i++) slot[i] <= '0;
        else if (accept)
            for (int i = 0; i < NUM_CLASS; i++)
                if (next_cnt == CNT_W'(i + 1)) slot[i] <= bus.score_data;

    // A frame is wrong exactly when score_last and the final slot do not coincide.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state            <= IDLE;
            cnt              <= '0;
            err_len          <= 1'b0;
            bus.result_class <= '0;
            bus.result_score <= '0;
        end else if (accept) begin
            cnt     <= next_cnt;
            err_len <= (state == COLLECT && err_len) || (full != bus.score_last);
            state   <= (full || bus.score_last) ? DECIDE : COLLECT;
        end else if (state == DECIDE) begin
            bus.result_class <= best_class;
            bus.result_score <= best_score;
            state            <= OUTPUT;
        end else if (state == OUTPUT && bus.result_ready)
            state <= IDLE;

`ifdef ARGMAX_FRAME_COUNT_EN
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            frame_cnt <= '0;
        else if (state == OUTPUT && bus.result_ready)
            frame_cnt <= frame_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_argmax_sequencer.sv
// tb_argmax_sequencer: table-driven frames plus back-pressure and mid-frame reset sequences.
module tb_argmax_sequencer;
    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic err_len;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_fc = 0;

    argmax_sequencer_if #(.DATA_W(16)) bus ();

`ifdef ARGMAX_FRAME_COUNT_EN
    logic [15:0] frame_cnt;
    argmax_sequencer dut (.clk(clk), .rst(rst), .bus(bus), .busy(busy), .err_len(err_len), .frame_cnt(frame_cnt));
`else
    argmax_sequencer dut (.clk(clk), .rst(rst), .bus(bus), .busy(busy), .err_len(err_len));
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0][15:0] s;
        int               n;
        bit               last_on;
        logic [31:0]      exp_class;
        logic [15:0]      exp_score;
        bit               exp_err;
    } vec_t;

    vec_t vt [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_fc();
`ifdef ARGMAX_FRAME_COUNT_EN
        chk("frame_cnt", 32'(frame_cnt), 32'(exp_fc[15:0]));
`endif
    endtask

    task automatic run_frame(input vec_t v);
        for (int k = 0; k < v.n; k++) begin
            @(negedge clk);
            bus.score_valid = 1'b1;
            bus.score_data  = v.s[k];
            bus.score_last  = v.last_on && (k == v.n - 1);
        end
        @(negedge clk);
        bus.score_valid = 1'b0;
        bus.score_last  = 1'b0;
        chk("decide_valid_low", 32'(bus.result_valid), 0);
        chk("decide_busy", 32'(busy), 1);
        @(negedge clk);
        chk("out_valid", 32'(bus.result_valid), 1);
        chk("out_class", bus.result_class, v.exp_class);
        chk("out_score", 32'($unsigned(bus.result_score)), 32'(v.exp_score));
        chk("out_err", 32'(err_len), 32'(v.exp_err));
        chk("out_ready_low", 32'(bus.score_ready), 0);
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;
        exp_fc++;
        chk("post_valid", 32'(bus.result_valid), 0);
        chk("post_busy", 32'(busy), 0);
        chk("post_class_hold", bus.result_class, v.exp_class);
        chk_fc();
    endtask

    initial begin
        for (int k = 0; k < 10; k++) begin
            vt[0].s[k] = 16'(k + 1);
            vt[1].s[k] = 16'h8000;
            vt[2].s[k] = 16'h0000;
            vt[3].s[k] = 16'h0000;
            vt[4].s[k] = 16'(9 - k);
            vt[5].s[k] = 16'd4;
            vt[6].s[k] = 16'h0000;
            vt[7].s[k] = 16'hFFFF;
        end
        vt[1].s[2] = 16'hFFFF;
        vt[2].s[3] = 16'd5;
        vt[2].s[6] = 16'd5;
        vt[3].s[0] = 16'hFFFD;
        vt[3].s[1] = 16'hFFFF;
        vt[3].s[2] = 16'hFFFE;
        vt[3].s[3] = 16'hFFFB;
        vt[6].s[0] = 16'hFFF9;
        vt[7].s[4] = 16'h7FFF;
        vt[7].s[5] = 16'h8000;
        vt[0].n = 10; vt[0].last_on = 1; vt[0].exp_class = 10; vt[0].exp_score = 16'd10;   vt[0].exp_err = 0;
        vt[1].n = 10; vt[1].last_on = 1; vt[1].exp_class = 3;  vt[1].exp_score = 16'hFFFF; vt[1].exp_err = 0;
        vt[2].n = 10; vt[2].last_on = 1; vt[2].exp_class = 7;  vt[2].exp_score = 16'd5;    vt[2].exp_err = 0;
        vt[3].n = 4;  vt[3].last_on = 1; vt[3].exp_class = 2;  vt[3].exp_score = 16'hFFFF; vt[3].exp_err = 1;
        vt[4].n = 10; vt[4].last_on = 0; vt[4].exp_class = 1;  vt[4].exp_score = 16'd9;    vt[4].exp_err = 1;
        vt[5].n = 10; vt[5].last_on = 1; vt[5].exp_class = 10; vt[5].exp_score = 16'd4;    vt[5].exp_err = 0;
        vt[6].n = 1;  vt[6].last_on = 1; vt[6].exp_class = 1;  vt[6].exp_score = 16'hFFF9; vt[6].exp_err = 1;
        vt[7].n = 10; vt[7].last_on = 1; vt[7].exp_class = 5;  vt[7].exp_score = 16'h7FFF; vt[7].exp_err = 0;

        rst = 1'b0;
        bus.score_valid  = 1'b0;
        bus.score_data   = '0;
        bus.score_last   = 1'b0;
        bus.result_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(bus.score_ready), 1);
        chk("rst_valid", 32'(bus.result_valid), 0);
        chk("rst_class", bus.result_class, 0);
        chk("rst_score", 32'($unsigned(bus.result_score)), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err_len), 0);
        chk_fc();

        for (int i = 0; i < 8; i++) run_frame(vt[i]);

        // Back-pressure: result held 20 cycles while a score is offered and must not be taken.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            bus.score_valid = 1'b1;
            bus.score_data  = 16'(k + 1);
            bus.score_last  = (k == 9);
        end
        @(negedge clk);
        bus.score_data = 16'd99;
        bus.score_last = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("hold_valid", 32'(bus.result_valid), 1);
            chk("hold_class", bus.result_class, 10);
            chk("hold_ready", 32'(bus.score_ready), 0);
        end
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;
        exp_fc++;
        chk("hs_valid", 32'(bus.result_valid), 0);
        chk("hs_busy", 32'(busy), 0);
        chk("hs_err", 32'(err_len), 0);
        chk_fc();
        @(negedge clk);
        bus.score_valid = 1'b0;
        bus.score_last  = 1'b0;
        chk("next_busy", 32'(busy), 1);
        chk("next_err", 32'(err_len), 1);
        @(negedge clk);
        chk("next_class", bus.result_class, 1);
        chk("next_score", 32'($unsigned(bus.result_score)), 99);
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;
        exp_fc++;
        chk_fc();

        // Reset in the middle of a frame discards it.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bus.score_valid = 1'b1;
            bus.score_data  = 16'd50;
            bus.score_last  = 1'b0;
        end
        @(negedge clk);
        bus.score_valid = 1'b0;
        rst = 1'b0;
        #1;
        exp_fc = 0;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_valid", 32'(bus.result_valid), 0);
        chk("mid_rst_class", bus.result_class, 0);
        chk("mid_rst_score", 32'($unsigned(bus.result_score)), 0);
        chk("mid_rst_err", 32'(err_len), 0);
        chk_fc();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("after_rst_ready", 32'(bus.score_ready), 1);
        run_frame(vt[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
